// File: rtl/otter_fetch_queue.sv
// OTTER instruction-fetch stage: owns the PC, issues one synchronous imem read per
// cycle under a credit limit, and buffers responses in a small prefetch queue for decode.
module otter_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL_D,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_TARGET,
  output logic        IMEM_RDEN,
  output logic [13:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DOUT,
  output logic        VALID_D,
  output logic [31:0] INSTR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_PLUS4_D
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic        r_inflight;
  ptr_t        r_rd_ptr;
  ptr_t        r_wr_ptr;
  cnt_t        r_count;
  logic [31:0] r_q_instr [DEPTH];
  logic [31:0] r_q_pc    [DEPTH];

  logic        w_pop;
  logic        w_push;
  logic [CW:0] w_credit;

  assign VALID_D = (r_count != '0);
  assign w_pop   = VALID_D & ~STALL_D & ~FLUSH;
  assign w_push  = r_inflight & ~FLUSH;

  // Slots already claimed once this cycle's pop is accounted for; the pop frees
  // a credit combinationally so fetch resumes the same cycle a stall drops.
  assign w_credit  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign IMEM_RDEN = ~RESET & ~FLUSH & (w_credit < (CW + 1)'(DEPTH));
  assign IMEM_ADDR = r_fetch_pc[15:2];

  assign INSTR_D    = VALID_D ? r_q_instr[r_rd_ptr]         : NOP;
  assign PC_D       = VALID_D ? r_q_pc[r_rd_ptr]            : 32'h0;
  assign PC_PLUS4_D = VALID_D ? r_q_pc[r_rd_ptr] + 32'd4    : 32'h0;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (FLUSH) begin
      r_fetch_pc <= FLUSH_TARGET & 32'hFFFF_FFFC;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= IMEM_RDEN;
      if (IMEM_RDEN) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: queue storage is not reset; VALID_D masks any stale entry, so a reset
  // here would only add fanout on RESET.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= IMEM_DOUT;
      r_q_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue: a scoreboard of expected PCs is loaded at
// reset/flush and drained whenever decode accepts an instruction.
module tb_otter_fetch_queue;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL_D = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] FLUSH_TARGET = 32'h0;
  logic        IMEM_RDEN;
  logic [13:0] IMEM_ADDR;
  logic [31:0] IMEM_DOUT = 32'h0;
  logic        VALID_D;
  logic [31:0] INSTR_D;
  logic [31:0] PC_D;
  logic [31:0] PC_PLUS4_D;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] sb [$];
  logic [31:0] held_pc;
  logic [31:0] held_instr;

  otter_fetch_queue #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .CLK(CLK), .RESET(RESET), .STALL_D(STALL_D), .FLUSH(FLUSH),
    .FLUSH_TARGET(FLUSH_TARGET), .IMEM_RDEN(IMEM_RDEN), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_DOUT(IMEM_DOUT), .VALID_D(VALID_D), .INSTR_D(INSTR_D), .PC_D(PC_D),
    .PC_PLUS4_D(PC_PLUS4_D)
  );

  always #5 CLK = ~CLK;

  // Synchronous instruction memory: word n holds 0x1000+n.
  always @(posedge CLK) if (IMEM_RDEN) IMEM_DOUT <= 32'h1000 + {18'h0, IMEM_ADDR};

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000 + {18'h0, pc[15:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic sb_restart(input logic [31:0] start);
    sb.delete();
    for (int k = 0; k < 64; k++) sb.push_back(start + 32'(4 * k));
  endtask

  // One cycle: drive inputs just after the rising edge, sample at the falling edge.
  task automatic tick(input logic s, input logic f, input logic [31:0] t);
    logic [31:0] e;
    @(posedge CLK); #1;
    STALL_D = s; FLUSH = f; FLUSH_TARGET = t;
    if (f) sb_restart(t & 32'hFFFF_FFFC);
    @(negedge CLK);
    if (VALID_D && !s && !f) begin
      if (sb.size() == 0) begin
        n_total++;
        $error("FAIL sb_underflow observed_pc=%h expected=none", PC_D);
      end else begin
        e = sb.pop_front();
        check("sb_pc", PC_D, e);
        check("sb_instr", INSTR_D, word_at(e));
        check("sb_pc4", PC_PLUS4_D, e + 32'd4);
      end
    end
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_valid", {31'h0, VALID_D}, 32'h0);
    check("rst_instr", INSTR_D, 32'h13);
    check("rst_pc", PC_D, 32'h0);
    check("rst_pc4", PC_PLUS4_D, 32'h0);
    check("rst_rden", {31'h0, IMEM_RDEN}, 32'h0);

    // Release between edges; first edge issues RESET_PC
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    sb_restart(32'h0);
    #1;
    check("first_rden", {31'h0, IMEM_RDEN}, 32'h1);
    check("first_addr", {18'h0, IMEM_ADDR}, 32'h0);
    tick(0, 0, 0);
    check("lat_valid_t1", {31'h0, VALID_D}, 32'h0);
    check("lat_addr_t1", {18'h0, IMEM_ADDR}, 32'h1);
    tick(0, 0, 0);
    check("lat_valid_t2", {31'h0, VALID_D}, 32'h1);
    check("lat_pc_t2", PC_D, 32'h0);
    repeat (6) tick(0, 0, 0);

    // Five-cycle stall: head frozen, fetch throttled, then seamless resume
    tick(1, 0, 0);
    held_pc = PC_D; held_instr = INSTR_D;
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      check("stall_pc", PC_D, held_pc);
      check("stall_instr", INSTR_D, held_instr);
      check("stall_rden", {31'h0, IMEM_RDEN}, 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0);
      check("resume_valid", {31'h0, VALID_D}, 32'h1);
    end

    // Flush to 0x40 mid-stream with a read in flight
    tick(0, 1, 32'h40);
    check("fl_rden_f", {31'h0, IMEM_RDEN}, 32'h0);
    tick(0, 0, 0);
    check("fl_valid_f1", {31'h0, VALID_D}, 32'h0);
    check("fl_rden_f1", {31'h0, IMEM_RDEN}, 32'h1);
    check("fl_addr_f1", {18'h0, IMEM_ADDR}, 32'h10);
    tick(0, 0, 0);
    check("fl_valid_f2", {31'h0, VALID_D}, 32'h0);
    tick(0, 0, 0);
    check("fl_valid_f3", {31'h0, VALID_D}, 32'h1);
    repeat (3) tick(0, 0, 0);

    // Flush together with stall from a full queue, target 0x80
    repeat (3) tick(1, 0, 0);
    tick(1, 1, 32'h80);
    tick(0, 0, 0);
    check("fs_valid_f1", {31'h0, VALID_D}, 32'h0);
    check("fs_addr_f1", {18'h0, IMEM_ADDR}, 32'h20);
    tick(0, 0, 0);
    check("fs_valid_f2", {31'h0, VALID_D}, 32'h0);
    tick(0, 0, 0);
    check("fs_valid_f3", {31'h0, VALID_D}, 32'h1);
    repeat (2) tick(0, 0, 0);

    // Back-to-back flushes: only the second target may surface
    tick(0, 1, 32'h100);
    tick(0, 1, 32'h200);
    tick(0, 0, 0);
    check("bb_valid_f1", {31'h0, VALID_D}, 32'h0);
    check("bb_addr_f1", {18'h0, IMEM_ADDR}, 32'h80);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("bb_pc_f3", PC_D, 32'h200);
    repeat (2) tick(0, 0, 0);

    // PC wrap: unaligned target rounds down, then wraps to zero
    tick(0, 1, 32'hFFFF_FFFE);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("wrap_pc_a", PC_D, 32'hFFFF_FFFC);
    check("wrap_pc4_a", PC_PLUS4_D, 32'h0);
    tick(0, 0, 0);
    check("wrap_pc_b", PC_D, 32'h0);
    check("wrap_pc4_b", PC_PLUS4_D, 32'h4);
    repeat (2) tick(0, 0, 0);

    // Asynchronous reset between edges mid-stream
    @(posedge CLK); #2;
    STALL_D = 1'b0; FLUSH = 1'b0;
    RESET = 1'b1;
    #1;
    check("arst_valid", {31'h0, VALID_D}, 32'h0);
    check("arst_instr", INSTR_D, 32'h13);
    check("arst_rden", {31'h0, IMEM_RDEN}, 32'h0);
    check("arst_pc", PC_D, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    sb_restart(32'h0);
    #1;
    check("arst_rel_rden", {31'h0, IMEM_RDEN}, 32'h1);
    check("arst_rel_addr", {18'h0, IMEM_ADDR}, 32'h0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("arst_rel_pc", PC_D, 32'h0);
    repeat (4) tick(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
